// File: rtl/uart_tx.sv
// UART transmitter: serialises bytes LSB-first as start/data/parity/stop frames.
// The frame format comes from a config-bus register and is sampled once per byte.
module uart_tx #(
  parameter int          OVERSAMPLE = 16,
  parameter logic [3:0]  CFG_ADDR   = 4'h2,
  parameter logic [7:0]  CFG_RESET  = 8'h03
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c_valid,
  input  logic [3:0] c_addr,
  input  logic [7:0] c_data,
  output logic       c_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int            TW       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q;
  logic [TW-1:0] tmr_q;
  logic [2:0]    bit_idx_q;
  logic          stop_idx_q;
  logic [7:0]    data_q;
  logic [4:0]    fmt_q;
  logic [7:0]    cfg_q;
  logic          par_q;
  logic          tx_q;
  logic          busy_q;

  logic          bit_end;
  logic [2:0]    last_idx;
  logic [2:0]    bit_idx_d;
  logic          par_en;
  logic          par_odd;
  logic          unused_cfg;

  assign bit_end    = (tmr_q == TMR_LAST);
  assign last_idx   = {1'b0, fmt_q[1:0]} + 3'd4;
  assign bit_idx_d  = bit_idx_q + 3'd1;
  assign par_en     = fmt_q[3] ^ fmt_q[2];
  assign par_odd    = (fmt_q[3:2] == 2'b10);
  // Reserved format bits are stored but have no function.
  assign unused_cfg = ^cfg_q[7:5];

  assign c_ready  = (state_q == S_IDLE);
  assign in_ready = (state_q == S_IDLE);
  assign tx       = tx_q;
  assign busy     = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      fmt_q      <= '0;
      cfg_q      <= CFG_RESET;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      if (c_valid && (state_q == S_IDLE) && (c_addr == CFG_ADDR)) begin
        cfg_q <= c_data;
      end

      if (state_q != S_IDLE) begin
        tmr_q <= bit_end ? '0 : tmr_q + TW'(1);
      end

      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          tmr_q  <= '0;
          if (in_valid) begin
            // cfg_q here is the pre-edge value, so a same-cycle write hits the next frame.
            data_q  <= in_data;
            fmt_q   <= cfg_q[4:0];
            state_q <= S_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
            tx_q      <= data_q[0];
            par_q     <= data_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == last_idx) begin
              if (par_en) begin
                state_q <= S_PARITY;
                tx_q    <= par_q ^ par_odd;
              end else begin
                state_q    <= S_STOP;
                tx_q       <= 1'b1;
                stop_idx_q <= 1'b0;
              end
            end else begin
              bit_idx_q <= bit_idx_d;
              tx_q      <= data_q[bit_idx_d];
              par_q     <= par_q ^ data_q[bit_idx_d];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_q    <= S_STOP;
            tx_q       <= 1'b1;
            stop_idx_q <= 1'b0;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (fmt_q[4] && !stop_idx_q) begin
              stop_idx_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
            tx_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed table, corner sequences and randomized frames
// compared against a bit-list reference model.
module tb_uart_tx;

  localparam int OS = 16;

  logic       clk;
  logic       rst_n;
  logic       c_valid;
  logic [3:0] c_addr;
  logic [7:0] c_data;
  logic       c_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;

  int tests = 0;
  int fails = 0;

  uart_tx #(.OVERSAMPLE(OS), .CFG_ADDR(4'h2), .CFG_RESET(8'h03)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .c_valid  (c_valid),
    .c_addr   (c_addr),
    .c_data   (c_data),
    .c_ready  (c_ready),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cfg_en;
    logic [7:0] cfg;
    logic [7:0] data;
    int         nbits;
    logic [11:0] line;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: list of line levels, one per bit period, derived from the frame rules.
  function automatic void model(input logic [7:0] d, input logic [7:0] f,
                                output logic [11:0] line, output int n);
    int   nd;
    logic par;
    line = '1;
    n = 0;
    line[n] = 1'b0; n++;
    nd = 5 + int'(f[1:0]);
    par = 1'b0;
    for (int i = 0; i < nd; i++) begin
      line[n] = d[i]; n++;
      par = par ^ d[i];
    end
    if (f[3:2] == 2'b01) begin line[n] = par;  n++; end
    if (f[3:2] == 2'b10) begin line[n] = ~par; n++; end
    line[n] = 1'b1; n++;
    if (f[4]) begin line[n] = 1'b1; n++; end
  endfunction

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    int guard = 0;
    @(negedge clk);
    c_valid = 1'b1; c_addr = a; c_data = d;
    while (!c_ready && guard < 500) begin @(negedge clk); guard++; end
    if (guard >= 500) chk("cfg_wait_timeout", 1, 0);
    @(posedge clk);
    #1 c_valid = 1'b0;
  endtask

  task automatic accept(input logic [7:0] d, input logic cw, input logic [7:0] cd);
    int guard = 0;
    @(negedge clk);
    in_data = d; in_valid = 1'b1;
    if (cw) begin c_valid = 1'b1; c_addr = 4'h2; c_data = cd; end
    while (!in_ready && guard < 500) begin @(negedge clk); guard++; end
    if (guard >= 500) chk("accept_wait_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    c_valid  = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Starts right after the accepting edge; returns at the first negedge with busy low.
  task automatic check_frame(input string nm, input logic [11:0] exp_line, input int exp_bits);
    logic        samp[$];
    int          rdy_hi = 0;
    int          wave_err = 0;
    logic [11:0] act_line = '0;
    logic [11:0] mask;
    int          idx;
    logic        e;
    @(negedge clk);
    while (busy && samp.size() < 400) begin
      samp.push_back(tx);
      if (in_ready || c_ready) rdy_hi++;
      @(negedge clk);
    end
    chk({nm, "_len"}, samp.size(), exp_bits * OS);
    for (int b = 0; b < exp_bits; b++) begin
      idx = b * OS + OS / 2;
      act_line[b] = (idx < samp.size()) ? samp[idx] : ~exp_line[b];
    end
    mask = 12'((1 << exp_bits) - 1);
    chk({nm, "_centres"}, int'(act_line & mask), int'(exp_line & mask));
    for (int k = 0; k < samp.size(); k++) begin
      e = (k / OS < exp_bits) ? exp_line[k / OS] : 1'b1;
      if (samp[k] !== e) wave_err++;
    end
    chk({nm, "_wave_errs"}, wave_err, 0);
    chk({nm, "_ready_while_busy"}, rdy_hi, 0);
    chk({nm, "_idle_tx"}, int'(tx), 1);
    chk({nm, "_idle_in_ready"}, int'(in_ready), 1);
  endtask

  vec_t        vecs[4];
  logic [7:0]  cur_fmt;
  logic [7:0]  frame_fmt;
  logic [7:0]  nf;
  logic [7:0]  d;
  logic [3:0]  a;
  logic [11:0] ml;
  int          mn;
  int          r;

  initial begin
    vecs[0] = '{1'b0, 8'h00, 8'h55, 10, 12'h2AA};
    vecs[1] = '{1'b1, 8'h06, 8'h41, 10, 12'h282};
    vecs[2] = '{1'b1, 8'h1B, 8'hFF, 12, 12'hFFE};
    vecs[3] = '{1'b1, 8'h03, 8'hA5, 10, 12'h34A};

    rst_n = 1'b0; c_valid = 1'b0; c_addr = '0; c_data = '0;
    in_data = '0; in_valid = 1'b0;
    #7;
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_c_ready", int'(c_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    cur_fmt = 8'h03;

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].cfg_en) begin
        cfg_write(4'h2, vecs[i].cfg);
        cur_fmt = vecs[i].cfg;
      end
      accept(vecs[i].data, 1'b0, 8'h00);
      check_frame($sformatf("vec%0d", i), vecs[i].line, vecs[i].nbits);
    end

    // Config write held through a frame only lands at the next IDLE cycle.
    accept(8'h5A, 1'b0, 8'h00);
    c_valid = 1'b1; c_addr = 4'h2; c_data = 8'h00;
    model(8'h5A, cur_fmt, ml, mn);
    check_frame("hold_frame", ml, mn);
    @(posedge clk);
    #1 c_valid = 1'b0;
    cur_fmt = 8'h00;
    accept(8'h1F, 1'b0, 8'h00);
    check_frame("hold_5n1", 12'h07E, 7);

    cfg_write(4'h2, 8'h03);
    cur_fmt = 8'h03;

    // Back-to-back with in_valid held: exactly one idle cycle between frames.
    @(negedge clk);
    in_data = 8'hA5; in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 8'h3C;
    model(8'hA5, cur_fmt, ml, mn);
    check_frame("b2b_first", ml, mn);
    @(posedge clk);
    #1 in_valid = 1'b0;
    model(8'h3C, cur_fmt, ml, mn);
    check_frame("b2b_second", ml, mn);

    for (int it = 0; it < 20; it++) begin
      r  = $urandom_range(0, 2);
      d  = 8'($urandom);
      nf = 8'($urandom);
      if (r == 0) begin
        a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h2;
        cfg_write(a, nf);
        if (a == 4'h2) cur_fmt = nf;
        frame_fmt = cur_fmt;
        accept(d, 1'b0, 8'h00);
      end else if (r == 1) begin
        frame_fmt = cur_fmt;
        accept(d, 1'b1, nf);
        cur_fmt = nf;
      end else begin
        frame_fmt = cur_fmt;
        accept(d, 1'b0, 8'h00);
      end
      model(d, frame_fmt, ml, mn);
      check_frame($sformatf("rnd%0d", it), ml, mn);
    end

    // Reset mid-frame: register was switched to 8O2 at acceptance, reset must restore 8N1.
    cfg_write(4'h2, 8'h03);
    accept(8'h00, 1'b1, 8'h1B);
    repeat (88) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_c_ready", int'(c_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    accept(8'h81, 1'b0, 8'h00);
    check_frame("after_rst", 12'h302, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
